// File: rtl/prbs_checker_if.sv
// prbs_checker_if: word stream into the PRBS checker and its lock/error status back out.
interface prbs_checker_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic                   clear;
  logic                   locked;
  logic                   word_error;
  logic [COUNT_WIDTH-1:0] bit_error_count;
  logic [COUNT_WIDTH-1:0] word_count;
  modport master (
    output in_data, in_valid, clear,
    input  locked, word_error, bit_error_count, word_count
  );
  modport slave (
    input  in_data, in_valid, clear,
    output locked, word_error, bit_error_count, word_count
  );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker with HUNT/VERIFY/LOCKED acquisition and error counters.
// S[W-1] holds the newest sequence bit; the next bit is ^(S & LFSR_POLY) and is shifted in at the top.
module prbs_checker #(
  parameter int                    LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
  parameter bit                    LFSR_INVERT   = 1'b1,
  parameter bit                    REVERSE       = 1'b0,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    UNLOCK_ERRORS = 8,
  parameter int                    COUNT_WIDTH   = 32
) (
  input logic           clk,
  input logic           rst_n,
  prbs_checker_if.slave bus
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(UNLOCK_ERRORS + 1);
  localparam int PW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t                 r_state, w_state_nx;
  logic [LFSR_WIDTH-1:0]  r_s, w_s_nx, w_pred, w_next;
  logic [MW-1:0]          r_match_cnt, w_match_nx, w_mc_inc;
  logic [EW-1:0]          r_err_run, w_err_nx, w_er_inc;
  logic                   r_locked, r_word_error, w_werr_nx, w_fb, w_match, w_bad;
  logic [COUNT_WIDTH-1:0] r_bec, r_wc, w_bec_nx, w_wc_nx;
  logic [COUNT_WIDTH:0]   w_bec_sum;
  logic [DATA_WIDTH-1:0]  w_exp, w_diff;
  logic [PW-1:0]          w_pop;
  // w_pred free-runs S on its own output; w_next loads the un-inverted received bits
  always_comb begin
    w_pred = r_s;
    w_next = r_s;
    w_exp  = '0;
    w_fb   = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_fb = ^(w_pred & LFSR_POLY);
      w_pred = {w_fb, w_pred[LFSR_WIDTH-1:1]};
      w_exp[REVERSE ? i : DATA_WIDTH-1-i] = w_fb ^ LFSR_INVERT;
      w_next = {bus.in_data[REVERSE ? i : DATA_WIDTH-1-i] ^ LFSR_INVERT, w_next[LFSR_WIDTH-1:1]};
    end
  end
  always_comb begin
    w_diff = bus.in_data ^ w_exp;
    w_pop  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) w_pop = w_pop + PW'(w_diff[i]);
  end
  assign w_bad     = |w_diff;
  assign w_match   = !w_bad && (r_s != '0);
  assign w_mc_inc  = r_match_cnt + 1'b1;
  assign w_er_inc  = r_err_run + 1'b1;
  assign w_bec_sum = {1'b0, r_bec} + (COUNT_WIDTH+1)'(w_pop);
  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_match_nx = r_match_cnt;
    w_err_nx   = r_err_run;
    w_werr_nx  = 1'b0;
    w_bec_nx   = r_bec;
    w_wc_nx    = r_wc;
    if (bus.in_valid) begin
      case (r_state)
        HUNT: begin
          w_s_nx = w_next;
          if (w_match) begin
            w_match_nx = MW'(1);
            w_state_nx = (LOCK_COUNT <= 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          w_s_nx     = w_next;
          w_match_nx = w_match ? w_mc_inc : '0;
          w_state_nx = !w_match ? HUNT : (w_mc_inc == MW'(LOCK_COUNT)) ? LOCKED : VERIFY;
        end
        LOCKED: begin
          w_bec_nx  = w_bec_sum[COUNT_WIDTH] ? '1 : w_bec_sum[COUNT_WIDTH-1:0];
          w_wc_nx   = (r_wc == '1) ? r_wc : r_wc + 1'b1;
          w_werr_nx = w_bad;
          w_err_nx  = w_bad ? w_er_inc : '0;
          w_s_nx    = w_pred;
          if (w_bad && w_er_inc == EW'(UNLOCK_ERRORS)) begin
            w_state_nx = HUNT;
            w_s_nx     = w_next;
            w_match_nx = '0;
            w_err_nx   = '0;
          end
        end
        default: w_state_nx = HUNT;
      endcase
    end
    if (bus.clear) begin
      w_bec_nx = '0;
      w_wc_nx  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_s          <= '0;
      r_match_cnt  <= '0;
      r_err_run    <= '0;
      r_locked     <= 1'b0;
      r_word_error <= 1'b0;
      r_bec        <= '0;
      r_wc         <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_s          <= w_s_nx;
      r_match_cnt  <= w_match_nx;
      r_err_run    <= w_err_nx;
      r_locked     <= (w_state_nx == LOCKED);
      r_word_error <= w_werr_nx;
      r_bec        <= w_bec_nx;
      r_wc         <= w_wc_nx;
    end
  end
  assign bus.locked          = r_locked;
  assign bus.word_error      = r_word_error;
  assign bus.bit_error_count = r_bec;
  assign bus.word_count      = r_wc;
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: random PRBS9 stimulus checked against a bit-queue reference model of the checker.
module tb_prbs_checker;
  localparam int DW = 8;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  bit mq[$];
  bit gq[$];
  int m_mode = 0, m_mc = 0, m_er = 0, m_bec = 0, m_wc = 0;
  logic m_locked = 1'b0, m_werr = 1'b0;
  always #5 clk = ~clk;
  prbs_checker_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();
  prbs_checker #(
    .LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INVERT(1'b0), .REVERSE(1'b0),
    .DATA_WIDTH(DW), .LOCK_COUNT(4), .UNLOCK_ERRORS(4), .COUNT_WIDTH(CW)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction
  // PRBS9 x^9+x^5+1: b[n] = b[n-9] ^ b[n-4]; queue index 0 is b[n-9], index 5 is b[n-4]
  function automatic logic [7:0] predict();
    bit c[$];
    bit nb;
    logic [7:0] e;
    c = mq;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      nb = c[0] ^ c[5];
      e = {e[6:0], nb};
      void'(c.pop_front());
      c.push_back(nb);
    end
    return e;
  endfunction
  function automatic logic [7:0] gen_word();
    bit nb;
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      nb = gq[0] ^ gq[5];
      w = {w[6:0], nb};
      void'(gq.pop_front());
      gq.push_back(nb);
    end
    return w;
  endfunction
  function automatic void push_word(logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      void'(mq.pop_front());
      mq.push_back(w[i]);
    end
  endfunction
  function automatic void model_reset();
    mq = {};
    for (int i = 0; i < 9; i++) mq.push_back(1'b0);
    m_mode = 0; m_mc = 0; m_er = 0; m_bec = 0; m_wc = 0;
    m_locked = 1'b0; m_werr = 1'b0;
  endfunction
  function automatic void model_word(logic [7:0] d);
    logic [7:0] e;
    int errs;
    bit nz;
    e = predict();
    errs = $countones(d ^ e);
    nz = 1'b0;
    foreach (mq[i]) nz |= mq[i];
    case (m_mode)
      0: begin
        push_word(d);
        if (errs == 0 && nz) begin m_mode = 1; m_mc = 1; end
      end
      1: begin
        push_word(d);
        if (errs == 0 && nz) begin
          m_mc++;
          if (m_mc == 4) m_mode = 2;
        end else begin
          m_mode = 0; m_mc = 0;
        end
      end
      default: begin
        m_bec = (m_bec + errs > 255) ? 255 : m_bec + errs;
        m_wc = (m_wc < 255) ? m_wc + 1 : 255;
        m_werr = (errs != 0);
        m_er = (errs != 0) ? m_er + 1 : 0;
        if (m_er == 4) begin
          m_mode = 0; m_mc = 0; m_er = 0;
          push_word(d);
        end else push_word(e);
      end
    endcase
  endfunction
  task automatic step(logic [7:0] d, logic v, logic c);
    bus.in_data = d;
    bus.in_valid = v;
    bus.clear = c;
    @(posedge clk);
    m_werr = 1'b0;
    if (v) model_word(d);
    if (c) begin m_bec = 0; m_wc = 0; end
    m_locked = (m_mode == 2);
    @(negedge clk);
  endtask
  task automatic clean(int n, int gap_pct);
    logic v;
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      d = v ? gen_word() : 8'($urandom);
      step(d, v, 1'b0);
    end
  endtask
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_word_error", int'(bus.word_error), 0);
    chk("rst_bec", int'(bus.bit_error_count), 0);
    chk("rst_wc", int'(bus.word_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    chk("locked", int'(bus.locked), int'(m_locked));
    chk("word_error", int'(bus.word_error), int'(m_werr));
    chk("bit_error_count", int'(bus.bit_error_count), m_bec);
    chk("word_count", int'(bus.word_count), m_wc);
  end
  initial begin
    int seed;
    int burst;
    logic v, c;
    logic [7:0] d;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.clear = 1'b0;
    seed = $urandom_range(1, 511);
    for (int i = 0; i < 9; i++) gq.push_back(seed[i]);
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clean(6, 0);
    chk("lock_within_6", int'(bus.locked), 1);
    step(gen_word(), 1'b1, 1'b1);
    chk("clear_wc", int'(bus.word_count), 0);
    clean(10, 0);
    chk("clean_bec", int'(bus.bit_error_count), 0);
    chk("clean_wc", int'(bus.word_count), 10);
    step(gen_word() ^ 8'h01, 1'b1, 1'b0);
    chk("flip_werr", int'(bus.word_error), 1);
    chk("flip_bec", int'(bus.bit_error_count), 1);
    chk("flip_locked", int'(bus.locked), 1);
    step(gen_word(), 1'b1, 1'b0);
    chk("after_flip_werr", int'(bus.word_error), 0);
    chk("after_flip_bec", int'(bus.bit_error_count), 1);
    chk("after_flip_wc", int'(bus.word_count), 12);
    step(gen_word(), 1'b1, 1'b1);
    repeat (3) step(gen_word() ^ 8'h81, 1'b1, 1'b0);
    chk("err3_locked", int'(bus.locked), 1);
    step(gen_word() ^ 8'h81, 1'b1, 1'b0);
    chk("err4_bec", int'(bus.bit_error_count), 8);
    chk("err4_locked", int'(bus.locked), 0);
    clean(60, 25);
    chk("relock", int'(bus.locked), 1);
    clean(320, 5);
    chk("wc_saturated", int'(bus.word_count), 255);
    step(gen_word() ^ 8'h10, 1'b1, 1'b1);
    chk("clear_err_bec", int'(bus.bit_error_count), 0);
    chk("clear_err_wc", int'(bus.word_count), 0);
    chk("clear_err_werr", int'(bus.word_error), 1);
    repeat (5) step(8'($urandom), 1'b0, 1'b0);
    chk("gap_wc", int'(bus.word_count), 0);
    chk("gap_locked", int'(bus.locked), 1);
    clean(3, 0);
    chk("post_gap_wc", int'(bus.word_count), 3);
    burst = 0;
    repeat (400) begin
      v = ($urandom_range(0, 3) != 0);
      d = v ? gen_word() : 8'($urandom);
      if (burst == 0 && $urandom_range(0, 49) == 0) burst = $urandom_range(3, 6);
      if (v && (burst > 0 || $urandom_range(0, 9) == 0)) d ^= 8'($urandom_range(1, 255));
      if (v && burst > 0) burst--;
      c = ($urandom_range(0, 31) == 0);
      step(d, v, c);
    end
    clean(20, 0);
    chk("pre_reset_locked", int'(bus.locked), 1);
    reset_pulse();
    clean(4, 0);
    chk("reacq_4_unlocked", int'(bus.locked), 0);
    clean(2, 0);
    chk("reacq_6_locked", int'(bus.locked), 1);
    repeat (60) step(8'h00, 1'b1, 1'b0);
    chk("zeros_unlocked", int'(bus.locked), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
